// File: rtl/weight_pkg.sv
// Shared definitions for the weight-memory read path: default weight width,
// reader FSM states and the lane-slice helper used to index packed row vectors.
package weight_pkg;

   localparam int DATA_WIDTH_DEF = 5;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      PRESENT,
      DONE
   } rd_state_e;

   // Bit offset of lane `lane` in a packed vector of `width`-bit lanes.
   function automatic int lane_base(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/weight_row_assembler.sv
// SIZE-lane capture register: writes wr_data into the addressed lane when
// wr_en is high; lanes hold their value otherwise and clear only on reset.
module weight_row_assembler
   import weight_pkg::*;
#(
   parameter int SIZE       = 8,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LANE_W     = $clog2(SIZE)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [LANE_W-1:0]          lane,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   output logic [SIZE*DATA_WIDTH-1:0] row_data
);

   genvar gi;
   generate
      for (gi = 0; gi < SIZE; gi++) begin : g_lane
         logic [DATA_WIDTH-1:0] lane_q;
         logic [DATA_WIDTH-1:0] lane_d;

         always_comb begin
            lane_d = lane_q;
            if (wr_en && (lane == LANE_W'(gi))) begin
               lane_d = wr_data;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lane_q <= '0;
            end else begin
               lane_q <= lane_d;
            end
         end

         assign row_data[lane_base(gi, DATA_WIDTH) +: DATA_WIDTH] = lane_q;
      end
   endgenerate

endmodule

// File: rtl/weight_mem_reader.sv
// Weight memory read sequencer: fetches the SIZE x SIZE matrix row by row and
// presents each row with valid/ready. Define WEIGHT_READER_TRANSPOSE_EN for column-major order.
module weight_mem_reader
   import weight_pkg::*;
#(
   parameter int SIZE       = 8,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int MEM_SIZE   = SIZE * SIZE,
   parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
   parameter int ROW_W      = $clog2(SIZE)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       rd_en,
   output logic [ADDR_WIDTH-1:0]      rd_addr,
   input  logic [DATA_WIDTH-1:0]      rd_data,
   output logic [SIZE*DATA_WIDTH-1:0] row_data,
   output logic [ROW_W-1:0]           row_idx,
   output logic                       row_valid,
   input  logic                       row_ready,
   output logic                       busy,
   output logic                       done
);

   localparam logic [ADDR_WIDTH-1:0] SIZE_A = ADDR_WIDTH'(SIZE);
   localparam logic [ROW_W-1:0]      LAST   = ROW_W'(SIZE - 1);

   rd_state_e         state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ROW_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  cap_lane_q, cap_lane_d;
   logic              cap_en_q, cap_en_d;
   logic [ADDR_WIDTH-1:0] fetch_addr;

   always_comb begin
`ifdef WEIGHT_READER_TRANSPOSE_EN
      fetch_addr = ADDR_WIDTH'(col_q) * SIZE_A + ADDR_WIDTH'(row_q);
`else
      fetch_addr = ADDR_WIDTH'(row_q) * SIZE_A + ADDR_WIDTH'(col_q);
`endif
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      rd_en     = 1'b0;
      rd_addr   = '0;
      row_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = FETCH;
               row_d   = '0;
               col_d   = '0;
            end
         end
         FETCH: begin
            rd_en   = 1'b1;
            rd_addr = fetch_addr;
            if (col_q == LAST) begin
               state_d = DRAIN;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         DRAIN: begin
            state_d = PRESENT;
         end
         PRESENT: begin
            row_valid = 1'b1;
            if (row_ready) begin
               if (row_q == LAST) begin
                  state_d = DONE;
               end else begin
                  row_d   = row_q + 1'b1;
                  col_d   = '0;
                  state_d = FETCH;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Read data arrives one cycle after the strobe, so the lane index lags col by one.
   always_comb begin
      cap_en_d   = rd_en;
      cap_lane_d = col_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         cap_lane_q <= '0;
         cap_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         cap_lane_q <= cap_lane_d;
         cap_en_q   <= cap_en_d;
      end
   end

   assign row_idx = row_q;

   weight_row_assembler #(
      .SIZE       (SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .LANE_W     (ROW_W)
   ) u_assembler (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (cap_en_q),
      .lane     (cap_lane_q),
      .wr_data  (rd_data),
      .row_data (row_data)
   );

endmodule

// File: tb/tb_weight_mem_reader.sv
// Self-checking bench for weight_mem_reader: scenario table with randomized memory
// and back-pressure against a row/column reference model, plus a mid-fetch reset sequence.
module tb_weight_mem_reader;
   import weight_pkg::*;

   localparam int SIZE = 8;
   localparam int DW   = 5;
   localparam int MEMS = SIZE * SIZE;
   localparam int AW   = $clog2(MEMS);
   localparam int RW   = $clog2(SIZE);

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic [DW-1:0]        rd_data;
   logic [SIZE*DW-1:0]   row_data;
   logic [RW-1:0]        row_idx;
   logic                 row_valid;
   logic                 row_ready;
   logic                 busy;
   logic                 done;

   logic [DW-1:0] mem [MEMS];

   int errors = 0;
   int checks = 0;

   weight_mem_reader #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .row_data  (row_data),
      .row_idx   (row_idx),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory model.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Address of matrix element presented as lane c of row r.
   function automatic int ref_addr(input int r, input int c);
`ifdef WEIGHT_READER_TRANSPOSE_EN
      return c * SIZE + r;
`else
      return r * SIZE + c;
`endif
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"},     64'(rd_en),     64'd0);
      check({tag, "_rd_addr"},   64'(rd_addr),   64'd0);
      check({tag, "_row_data"},  64'(row_data),  64'd0);
      check({tag, "_row_idx"},   64'(row_idx),   64'd0);
      check({tag, "_row_valid"}, 64'(row_valid), 64'd0);
      check({tag, "_busy"},      64'(busy),      64'd0);
      check({tag, "_done"},      64'(done),      64'd0);
   endtask

   typedef struct {
      int mem_mode;     // 0: addr mod 32, 1: random
      int stall_row;    // row held off with ready=0, -1 for none
      int stall_len;
      bit rand_ready;
      bit poke_start;   // pulse start during FETCH and PRESENT
      int exp_done;     // expected done cycle, -1 to derive from stall count
   } vec_t;

   task automatic run(input vec_t v, input int idx);
      int cyc, rows_seen, rd_cnt, stall_cnt, stalls, done_cnt, done_cyc, next_valid;
      bit prev_valid, finished, rdy;
      logic [SIZE*DW-1:0] exp_row, held;
      string tag;
      tag = $sformatf("v%0d", idx);
      for (int a = 0; a < MEMS; a++)
         mem[a] = (v.mem_mode == 0) ? DW'(a % 32) : DW'($urandom);
      @(negedge clk);
      start = 1'b1;
      row_ready = 1'b1;
      @(posedge clk);
      cyc = 0; rows_seen = 0; rd_cnt = 0; stall_cnt = 0; stalls = 0;
      done_cnt = 0; done_cyc = -1; next_valid = SIZE + 2;
      prev_valid = 1'b0; finished = 1'b0; held = '0;
      while (!finished && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (rd_en) begin
            check({tag, "_rd_addr"}, 64'(rd_addr), 64'(ref_addr(rows_seen, rd_cnt)));
            check({tag, "_rd_in_row"}, 64'(rd_cnt < SIZE), 64'd1);
            rd_cnt++;
         end else begin
            check({tag, "_rd_addr_idle"}, 64'(rd_addr), 64'd0);
         end
         check({tag, "_busy"}, 64'(busy), 64'((done_cyc < 0) || (cyc <= done_cyc)));
         if (row_valid) begin
            check({tag, "_rd_during_present"}, 64'(rd_en), 64'd0);
            if (!prev_valid) begin
               check({tag, "_valid_cycle"}, 64'(cyc), 64'(next_valid));
               for (int c = 0; c < SIZE; c++)
                  exp_row[lane_base(c, DW) +: DW] = mem[ref_addr(rows_seen, c)];
               check({tag, "_row_idx"}, 64'(row_idx), 64'(rows_seen));
               check({tag, "_row_data"}, 64'(row_data), 64'(exp_row));
               held = row_data;
            end else begin
               check({tag, "_hold_data"}, 64'(row_data), 64'(held));
               check({tag, "_hold_idx"}, 64'(row_idx), 64'(rows_seen));
            end
         end
         if (row_valid && rows_seen == v.stall_row && stall_cnt < v.stall_len) begin
            rdy = 1'b0;
            stall_cnt++;
         end else if (v.rand_ready) begin
            rdy = ($urandom % 4) != 0;
         end else begin
            rdy = 1'b1;
         end
         row_ready = rdy;
         start = v.poke_start && (cyc == 3 || (row_valid && rows_seen == 1));
         if (row_valid && rdy) begin
            rows_seen++;
            rd_cnt = 0;
            next_valid = cyc + SIZE + 2;
         end else if (row_valid) begin
            stalls++;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               check({tag, "_done_cycle"}, 64'(cyc),
                     64'((v.exp_done > 0) ? v.exp_done : SIZE * (SIZE + 2) + 1 + stalls));
            end
         end
         prev_valid = row_valid;
         if (done_cyc > 0 && cyc >= done_cyc + 2) finished = 1'b1;
      end
      start = 1'b0;
      check({tag, "_finished"}, 64'(finished), 64'd1);
      check({tag, "_rows"}, 64'(rows_seen), 64'(SIZE));
      check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      check({tag, "_last_row_kept"}, 64'(row_data), 64'(held));
   endtask

   task automatic reset_mid_fetch();
      bit found;
      bit bad;
      for (int a = 0; a < MEMS; a++) mem[a] = DW'(a % 32);
      @(negedge clk);
      start = 1'b1;
      row_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (rd_en && row_idx == RW'(3)) found = 1'b1;
      end
      check("rst_reach_row3", 64'(found), 64'd1);
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (row_valid || busy || rd_en || done) bad = 1'b1;
      end
      check("rst_stays_idle", 64'(bad), 64'd0);
   endtask

   initial begin
      vec_t vecs[5];
      vecs[0] = '{mem_mode: 0, stall_row: -1, stall_len: 0,  rand_ready: 1'b0, poke_start: 1'b0, exp_done: 81};
      vecs[1] = '{mem_mode: 0, stall_row: 2,  stall_len: 20, rand_ready: 1'b0, poke_start: 1'b0, exp_done: 101};
      vecs[2] = '{mem_mode: 1, stall_row: -1, stall_len: 0,  rand_ready: 1'b0, poke_start: 1'b1, exp_done: 81};
      vecs[3] = '{mem_mode: 1, stall_row: -1, stall_len: 0,  rand_ready: 1'b1, poke_start: 1'b0, exp_done: -1};
      vecs[4] = '{mem_mode: 1, stall_row: 5,  stall_len: 7,  rand_ready: 1'b1, poke_start: 1'b1, exp_done: -1};

      rst = 1'b1;
      start = 1'b0;
      row_ready = 1'b0;
      for (int a = 0; a < MEMS; a++) mem[a] = '0;
      #1;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);

      reset_mid_fetch();

      for (int i = 0; i < 5; i++) begin
         run(vecs[i], i);
         $display("vector %0d: mem_mode=%0d stall_row=%0d stall_len=%0d rand_ready=%0d poke=%0d errors so far=%0d",
                  i, vecs[i].mem_mode, vecs[i].stall_row, vecs[i].stall_len,
                  vecs[i].rand_ready, vecs[i].poke_start, errors);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/weight_mem_reader.md
# weight_mem_reader

Read-side sequencer for the weight memory. After weights have been loaded, it fetches the SIZE×SIZE 5-bit weight matrix one row at a time through the memory's synchronous read port. Each row is assembled into a SIZE-lane vector and handed to the systolic-array weight preload path with a valid/ready handshake. It sits between the weight memory and the PE-array preload logic and reports busy/done to the top-level controller.

## Interface
- SIZE, 8, array dimension; legal range SIZE ≥ 2.
- DATA_WIDTH, 5, weight width in bits.
- MEM_SIZE, SIZE*SIZE, number of weight words.
- ADDR_WIDTH, $clog2(MEM_SIZE), memory address width.
- ROW_W, $clog2(SIZE), row index width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to read the whole matrix; only sampled in IDLE.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_WIDTH  memory read address.
- rd_data  in  DATA_WIDTH  read data, valid the cycle after rd_en.
- row_data  out  SIZE*DATA_WIDTH  assembled row; lane c = bits [c*DATA_WIDTH +: DATA_WIDTH].
- row_idx  out  ROW_W  index of the row currently presented.
- row_valid  out  1  row_data/row_idx are valid.
- row_ready  in  1  consumer accepts the row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.

## Operation
- FSM states: IDLE, FETCH, DRAIN, PRESENT, DONE.
- IDLE: start=1 → FETCH with row=0, col=0. In any other state, start is ignored.
- FETCH:
  - Each cycle drives rd_en=1 and rd_addr=row*SIZE+col, then increments col.
  - After col=SIZE-1 is issued → DRAIN.
  - No overflow is possible: the maximum address is MEM_SIZE-1.
- Capture: rd_data is written into lane c_d, where c_d is col delayed by one cycle. The write happens in the cycle following each rd_en.
- DRAIN: captures the final lane → PRESENT.
- PRESENT:
  - row_valid=1. row_data and row_idx are held stable until row_ready=1.
  - On handshake with row<SIZE-1: row++, col=0 → FETCH.
  - On handshake with row=SIZE-1 → DONE.
- DONE: done=1 for one cycle → IDLE.
- rd_addr is 0 whenever rd_en=0.
- row_ready while row_valid=0 has no effect.
- row_data keeps the last accepted row after DONE. It is cleared only by reset.

## Timing
- Reset values: state IDLE; row, col, c_d = 0; rd_en=0, rd_addr=0, row_data=0, row_idx=0, row_valid=0, busy=0, done=0.
- Cycle numbering: the edge that samples start is edge 0, and cycle k is the cycle after edge k-1.
- Cycles 1..SIZE: addresses 0..SIZE-1 are issued.
- Row 0 row_valid rises in cycle SIZE+2.
- With row_ready held at 1, the row period is SIZE+2 cycles. done pulses SIZE*(SIZE+2)+1 cycles after edge 0.
- Reset asserted mid-operation: all outputs return to reset values immediately. No partial row is presented after reset releases.
- Back-pressure may last indefinitely. No reads are issued while in PRESENT.

## Configuration
- WEIGHT_READER_TRANSPOSE_EN
  - Defined: addresses are column-major, rd_addr=col*SIZE+row, so the presented "row" r is matrix column r.
  - Undefined: row-major, as specified above.
  - Timing and handshake are identical in both modes.

## Structure
- Shared package weight_pkg holds:
  - the DATA_WIDTH default;
  - the FSM state enum (IDLE, FETCH, DRAIN, PRESENT, DONE);
  - a lane-slice helper function.
- Sub-module weight_row_assembler contains the SIZE-lane capture register. Its inputs are wr_en, lane index and data, plus a clear on reset.
- The FSM, counters and address generation stay in weight_mem_reader.

## Test plan
- Reset mid-FETCH, row 3 (SIZE=8): rst pulse → all outputs 0 in the same cycle; IDLE after release; no spurious row_valid.
- Memory holds value = addr mod 32; start with row_ready=1 → 8 rows; row r lane c = (8r+c) mod 32; row_valid first high in cycle 10; done in cycle 81.
- Row 2 back-pressure: row_ready=0 for 20 cycles on row 2 → row_data and row_idx=2 stable; rd_en=0 throughout; resume → row 3 valid 10 cycles after acceptance.
- start pulsed while busy, during FETCH and during PRESENT → ignored; exactly 8 rows and a single done pulse.
- WEIGHT_READER_TRANSPOSE_EN defined, same memory contents → row r lane c = (8c+r) mod 32; cycle counts unchanged.
